mvd_mvp_sel: RTL

//  Sequential AMVP predictor selector for the FME -> MVD path. For one PU it reads up to
//  MAX_CAND MVP candidates from the candidate buffer, presents each with the PU's fmv to
//  an external mvd_getBits instance, and keeps the candidate with the lowest MVD bit cost.
//  On completion it returns mvp index, MVD and bit cost to the mode-decision/cost stage.

---
 rtl/mvd_mvp_sel.sv | 114 +++++++++++
 1 files changed

// File: rtl/mvd_mvp_sel.sv
// Sequential AMVP predictor selector: streams up to MAX_CAND candidates past an external
// mvd_getBits instance and keeps the valid candidate with the lowest MVD bit cost.
module mvd_mvp_sel #(
  parameter int unsigned FMV_W    = 14,
  parameter int unsigned MVD_W    = 16,
  parameter int unsigned MAX_CAND = 4,
  localparam int unsigned IDX_W   = $clog2(MAX_CAND)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start_i,
  input  logic [2:0]           cand_num_i,
  input  logic [2*FMV_W-1:0]   mv_i,
  output logic                 cand_rd_en_o,
  output logic [IDX_W-1:0]     cand_rd_addr_o,
  input  logic [2*FMV_W:0]     cand_rd_data_i,
  output logic [2*FMV_W-1:0]   gb_mv_o,
  output logic [2*FMV_W-1:0]   gb_mvp_o,
  input  logic [5:0]           gb_bits_i,
  input  logic [2*MVD_W-1:0]   gb_mvd_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 best_vld_o,
  output logic [IDX_W-1:0]     best_idx_o,
  output logic [2*MVD_W-1:0]   best_mvd_o,
  output logic [5:0]           best_bits_o
);

  localparam int unsigned NUM_W = 3;

  typedef enum logic [1:0] {StIdle, StRead, StDrain, StDone} state_e;

  state_e               state_q, state_d;
  logic [2*FMV_W-1:0]   mv_q;
  logic [NUM_W-1:0]     num_q, num_clamp;
  logic [IDX_W-1:0]     addr_q, cmp_idx_q;
  logic                 rd_pend_q;
  logic                 best_vld_q;
  logic [IDX_W-1:0]     best_idx_q;
  logic [2*MVD_W-1:0]   best_mvd_q;
  logic [5:0]           best_bits_q;
  logic                 start_go, last_addr, cand_vld, upd;

  assign num_clamp = (cand_num_i > NUM_W'(MAX_CAND)) ? NUM_W'(MAX_CAND) : cand_num_i;
  assign start_go  = (state_q == StIdle) && start_i;
  assign last_addr = (NUM_W'(addr_q) + NUM_W'(1)) == num_q;
  assign cand_vld  = cand_rd_data_i[2*FMV_W];
  // Strict less-than so that ties keep the earlier (lower-index) candidate.
  assign upd       = rd_pend_q && cand_vld && (gb_bits_i < best_bits_q);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) state_d = (num_clamp == '0) ? StDone : StRead;
      end
      StRead: begin
        if (last_addr) state_d = StDrain;
      end
      StDrain: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StIdle;
      mv_q        <= '0;
      num_q       <= '0;
      addr_q      <= '0;
      cmp_idx_q   <= '0;
      rd_pend_q   <= 1'b0;
      best_vld_q  <= 1'b0;
      best_idx_q  <= '0;
      best_mvd_q  <= '0;
      best_bits_q <= 6'h3F;
    end else begin
      state_q   <= state_d;
      rd_pend_q <= cand_rd_en_o;
      cmp_idx_q <= addr_q;
      if (start_go) begin
        mv_q        <= mv_i;
        num_q       <= num_clamp;
        addr_q      <= '0;
        best_vld_q  <= 1'b0;
        best_idx_q  <= '0;
        best_mvd_q  <= '0;
        best_bits_q <= 6'h3F;
      end else begin
        if (state_q == StRead) addr_q <= addr_q + IDX_W'(1);
        if (upd) begin
          best_vld_q  <= 1'b1;
          best_idx_q  <= cmp_idx_q;
          best_mvd_q  <= gb_mvd_i;
          best_bits_q <= gb_bits_i;
        end
      end
    end
  end

  assign cand_rd_en_o   = (state_q == StRead);
  assign cand_rd_addr_o = addr_q;
  assign gb_mv_o        = mv_q;
  // Only forward buffer data while a read is in flight; otherwise hold the bus at zero.
  assign gb_mvp_o       = rd_pend_q ? cand_rd_data_i[2*FMV_W-1:0] : '0;
  assign busy_o         = (state_q != StIdle);
  assign done_o         = (state_q == StDone);
  assign best_vld_o     = best_vld_q;
  assign best_idx_o     = best_idx_q;
  assign best_mvd_o     = best_mvd_q;
  assign best_bits_o    = best_bits_q;

endmodule
